panel_compositor: RTL and testbench

PANEL_COMPOSITOR -- requirements
Module: panel_compositor

---
 rtl/panel_compositor.sv | 107 ++++++++++
 tb/tb_panel_compositor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/panel_compositor.sv
// panel_compositor: side-by-side panel layout with click-to-focus FSM; optional mouse cursor via CURSOR_EN
module panel_compositor #(
    parameter int CORDW      = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int NUM_PANELS = 2,
    parameter int MARGIN     = 10,
    parameter int GAP        = 10
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             frame_start,
    input  logic [CORDW-1:0] mouse_x,
    input  logic [CORDW-1:0] mouse_y,
    input  logic [2:0]       mouse_btn,
    output logic [3:0]       paint_r,
    output logic [3:0]       paint_g,
    output logic [3:0]       paint_b,
    output logic [2:0]       sel_panel,
    output logic             focused
);
    localparam int PW = (H_RES - 2*MARGIN - (NUM_PANELS-1)*GAP) / NUM_PANELS;
    typedef logic [CORDW:0] c_t;
    localparam c_t LO  = c_t'(MARGIN);
    localparam c_t Y1  = c_t'(V_RES - MARGIN - 1);
    localparam c_t FX1 = c_t'(H_RES - MARGIN - 1);
    typedef enum logic [1:0] {HOME, ARM_FOCUS, FOCUS, ARM_HOME} state_t;
    state_t state, state_n;
    logic [1:0] rst_q;
    logic rst_s;
    logic [2:0] btn_s1, btn_s2, btn_q, click, pend, pend_n, sel_n;
    logic foc_n, grey, hover, btn_unused;
    c_t mx, my, bx, by;
    logic [3:0] mh, bh;
    logic [11:0] colour;
    // Assert asynchronously, release two clocks after rst_n rises
    always_ff @(posedge clk_pix or negedge rst_n)
        if (!rst_n) rst_q <= '0;
        else rst_q <= {rst_q[0], 1'b1};
    assign rst_s = rst_q[1];
    // Returns {hit, panel index} for a point
    function automatic logic [3:0] hit(c_t x, c_t y);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_PANELS; i++)
            if (x >= c_t'(MARGIN + i*(PW+GAP)) && x <= c_t'(MARGIN + i*(PW+GAP) + PW - 1) && y >= LO && y <= Y1)
                r = {1'b1, 3'(i)};
        return r;
    endfunction
    assign bx = {1'b0, sx};
    assign by = {1'b0, sy};
    assign mh = hit(mx, my);
    assign bh = hit(bx, by);
    assign click = btn_s2 & ~btn_q;
    assign btn_unused = click[2];
    always_comb begin
        state_n = state;
        pend_n = pend;
        sel_n = sel_panel;
        foc_n = focused;
        unique case (state)
            HOME:      if (click[0] && mh[3]) begin pend_n = mh[2:0]; state_n = ARM_FOCUS; end
            ARM_FOCUS: if (frame_start) begin sel_n = pend; foc_n = 1'b1; state_n = FOCUS; end
            FOCUS:     if (click[1]) state_n = ARM_HOME;
            ARM_HOME:  if (frame_start) begin foc_n = 1'b0; state_n = HOME; end
        endcase
    end
    // Layout follows the committed mode, so ARM_* states keep drawing the old one
    always_comb begin
        hover = bh[3] && mh[3] && bh[2:0] == mh[2:0];
        grey = focused ? (bx >= LO && bx <= FX1 && by >= LO && by <= Y1) : bh[3];
        colour = !grey ? 12'h90F : (hover && !focused) ? 12'hCCC : 12'h999;
`ifdef CURSOR_EN
        if (bx >= mx && bx <= mx + c_t'(3) && by >= my && by <= my + c_t'(3)) colour = 12'hFFF;
`endif
        if (!de) colour = 12'h000;
    end
    always_ff @(posedge clk_pix or negedge rst_s)
        if (!rst_s) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_q <= '0;
            mx <= '0;
            my <= '0;
            state <= HOME;
            pend <= '0;
            sel_panel <= '0;
            focused <= 1'b0;
            {paint_r, paint_g, paint_b} <= '0;
        end else begin
            btn_s1 <= mouse_btn;
            btn_s2 <= btn_s1;
            btn_q <= btn_s2;
            if (frame_start) begin
                mx <= {1'b0, mouse_x};
                my <= {1'b0, mouse_y};
            end
            state <= state_n;
            pend <= pend_n;
            sel_panel <= sel_n;
            focused <= foc_n;
            {paint_r, paint_g, paint_b} <= colour;
        end
endmodule

// File: tb/tb_panel_compositor.sv
// tb_panel_compositor: directed scoreboard bench for panel_compositor
module tb_panel_compositor;
    logic clk_pix = 1'b0;
    logic rst_n, de, frame_start;
    logic [9:0] sx, sy, mouse_x, mouse_y;
    logic [2:0] mouse_btn, sel_panel;
    logic [3:0] paint_r, paint_g, paint_b;
    logic focused;
    logic [11:0] pix;
    logic [11:0] sb[$];
    int total = 0, bad = 0;
`ifdef CURSOR_EN
    localparam logic [11:0] CUR = 12'hFFF;
`else
    localparam logic [11:0] CUR = 12'hCCC;
`endif
    panel_compositor dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy), .de(de),
        .frame_start(frame_start), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .mouse_btn(mouse_btn), .paint_r(paint_r), .paint_g(paint_g),
        .paint_b(paint_b), .sel_panel(sel_panel), .focused(focused)
    );
    assign pix = {paint_r, paint_g, paint_b};
    always #5 clk_pix = ~clk_pix;
    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic px(string tag, int x, int y, logic [11:0] e);
        @(negedge clk_pix);
        sx = 10'(x);
        sy = 10'(y);
        de = 1'b1;
        sb.push_back(e);
        @(negedge clk_pix);
        de = 1'b0;
        chk(tag, pix, sb.pop_front());
    endtask
    task automatic fs();
        @(negedge clk_pix);
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
    endtask
    task automatic mouse(int x, int y);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
        fs();
    endtask
    task automatic press(logic [2:0] b);
        @(negedge clk_pix);
        mouse_btn = b;
        repeat (4) @(negedge clk_pix);
        mouse_btn = '0;
        repeat (4) @(negedge clk_pix);
    endtask
    initial begin
        rst_n = 1'b0;
        de = 1'b0;
        frame_start = 1'b0;
        sx = '0;
        sy = '0;
        mouse_x = 10'd1000;
        mouse_y = 10'd1000;
        mouse_btn = '0;
        #23;
        chk("rst_paint", pix, 12'h000);
        chk("rst_focused", {11'd0, focused}, 12'd0);
        chk("rst_sel", {9'd0, sel_panel}, 12'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_pix);
        fs();
        px("bg_origin", 0, 0, 12'h90F);
        px("panel0", 100, 100, 12'h999);
        @(negedge clk_pix);
        sx = 10'd100; sy = 10'd100; de = 1'b0;
        sb.push_back(12'h000);
        @(negedge clk_pix);
        chk("de_off", pix, sb.pop_front());
        px("corner_in", 10, 10, 12'h999);
        px("left_edge_out", 9, 10, 12'h90F);
        px("p0_br_in", 314, 469, 12'h999);
        px("p0_right_out", 315, 100, 12'h90F);
        px("gap_home", 320, 100, 12'h90F);
        px("p1_bottom_out", 325, 470, 12'h90F);
        px("p1_right_in", 629, 100, 12'h999);
        px("p1_right_out", 630, 100, 12'h90F);
        mouse(100, 100);
        px("hover_at_mouse", 100, 100, CUR);
        px("other_panel", 400, 100, 12'h999);
        px("hover_p0", 200, 200, 12'hCCC);
        mouse(50, 50);
        px("cursor", 52, 51, CUR);
        px("below_cursor", 53, 54, 12'hCCC);
        mouse(320, 100);
        press(3'b001);
        fs();
        chk("gap_click", {11'd0, focused}, 12'd0);
        mouse(5, 5);
        press(3'b001);
        fs();
        chk("out_click", {11'd0, focused}, 12'd0);
        mouse(400, 100);
        press(3'b001);
        chk("armed_not_focused", {11'd0, focused}, 12'd0);
        px("armed_home_layout", 320, 100, 12'h90F);
        fs();
        chk("focus_on", {11'd0, focused}, 12'd1);
        chk("focus_sel", {9'd0, sel_panel}, 12'd1);
        px("focus_p0", 100, 100, 12'h999);
        px("focus_gap", 320, 100, 12'h999);
        px("focus_left_out", 5, 100, 12'h90F);
        px("focus_right_out", 630, 100, 12'h90F);
        px("focus_top_out", 320, 9, 12'h90F);
        press(3'b101);
        fs();
        chk("lm_ignored", {11'd0, focused}, 12'd1);
        press(3'b011);
        chk("arm_home_still", {11'd0, focused}, 12'd1);
        px("arm_home_layout", 320, 100, 12'h999);
        fs();
        chk("home_again", {11'd0, focused}, 12'd0);
        chk("sel_retained", {9'd0, sel_panel}, 12'd1);
        px("gap_restored", 320, 100, 12'h90F);
        press(3'b011);
        chk("lr_home_armed", {11'd0, focused}, 12'd0);
        @(negedge clk_pix);
        sx = 10'd100; sy = 10'd100; de = 1'b1;
        @(posedge clk_pix);
        #1;
        chk("pre_reset_paint", pix, 12'h999);
        rst_n = 1'b0;
        #1;
        chk("reset_paint", pix, 12'h000);
        chk("reset_focused", {11'd0, focused}, 12'd0);
        de = 1'b0;
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_pix);
        fs();
        chk("no_focus_after_rst", {11'd0, focused}, 12'd0);
        chk("sel_after_rst", {9'd0, sel_panel}, 12'd0);
        px("home_after_rst", 100, 100, 12'h999);
        px("hover_after_rst", 410, 100, 12'hCCC);
        chk("sb_drained", 12'(sb.size()), 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
